// File: rtl/game_pkg.sv
// Shared command encoding and PS/2 set-2 scan codes for the game datapath.
package game_pkg;

   typedef enum logic [2:0] {
      CMD_NOP     = 3'd0,
      CMD_LEFT    = 3'd1,
      CMD_RIGHT   = 3'd2,
      CMD_ROTATE  = 3'd3,
      CMD_SOFT    = 3'd4,
      CMD_HARD    = 3'd5,
      CMD_GRAVITY = 3'd6
   } cmd_e;

   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_SPACE = 8'h29;
   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BRK   = 8'hF0;

   // Arrow keys decode identically with or without the E0 prefix.
   function automatic cmd_e decode_scan(input logic [7:0] code);
      case (code)
         SC_LEFT:  return CMD_LEFT;
         SC_RIGHT: return CMD_RIGHT;
         SC_UP:    return CMD_ROTATE;
         SC_DOWN:  return CMD_SOFT;
         SC_SPACE: return CMD_HARD;
         default:  return CMD_NOP;
      endcase
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO for 3-bit key commands; head is visible combinationally.
module cmd_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_push,
   input  logic [2:0]               i_push_data,
   input  logic                     i_pop,
   output logic [2:0]               o_head,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [2:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0] count_reg, count_next;
   logic          do_push, do_pop;

   assign o_full  = (count_reg == CW'(DEPTH));
   assign o_empty = (count_reg == '0);
   assign o_count = count_reg;
   assign o_head  = mem[rd_ptr_reg];

   // A pop frees the slot, so a push alongside it is accepted even when full.
   assign do_pop  = i_pop && !o_empty;
   assign do_push = i_push && (!o_full || do_pop);

   always_comb begin
      count_next = count_reg;
      case ({do_push, do_pop})
         2'b10:   count_next = count_reg + CW'(1);
         2'b01:   count_next = count_reg - CW'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (do_push) mem[wr_ptr_reg] <= i_push_data;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         count_reg <= count_next;
      end
   end

endmodule

// File: rtl/game_cmd_scheduler.sv
// Decodes keyboard scan codes, times gravity, and issues at most one gravity
// and one key command per frame to the board engine over valid/ready.
module game_cmd_scheduler
   import game_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int TICK_W     = 27
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_key_valid,
   input  logic [7:0]                    i_key_code,
   input  logic                          i_frame_start,
   input  logic                          i_pause,
   input  logic [TICK_W-1:0]             i_gravity_period,
   output logic                          o_cmd_valid,
   output cmd_e                          o_cmd,
   input  logic                          i_cmd_ready,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
   output logic                          o_overflow
);

   typedef enum logic [1:0] {IDLE, GRAV, KEY} state_e;

   state_e              state_reg, state_next;
   logic                valid_reg, valid_next;
   cmd_e                cmd_reg, cmd_next;
   logic                ext_reg, ext_next;
   logic                brk_reg, brk_next;
   logic                overflow_reg, overflow_next;
   logic                grav_reg, grav_next;
   logic [TICK_W-1:0]   timer_reg, timer_next;
   logic [TICK_W-1:0]   period_eff;
   cmd_e                key_cmd;
   logic                push, pop, tick;
   logic                accept, accept_hard, accept_grav;
   logic [2:0]          fifo_head;
   logic                fifo_full, fifo_empty;

   // Scan-code decode: a byte following F0 is a key release and is discarded.
   always_comb begin
      key_cmd  = decode_scan(i_key_code);
      ext_next = ext_reg;
      brk_next = brk_reg;
      push     = 1'b0;
      if (i_key_valid) begin
         ext_next = (i_key_code == SC_EXT);
         brk_next = !brk_reg && (i_key_code == SC_BRK);
         push     = !brk_reg && (key_cmd != CMD_NOP);
      end
   end

   cmd_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_push      (push),
      .i_push_data (key_cmd),
      .i_pop       (pop),
      .o_head      (fifo_head),
      .o_full      (fifo_full),
      .o_empty     (fifo_empty),
      .o_count     (o_fifo_count)
   );

   assign overflow_next = overflow_reg | (push && fifo_full && !pop);

   assign accept      = valid_reg && i_cmd_ready;
   assign accept_hard = accept && (cmd_reg == CMD_HARD);
   assign accept_grav = accept && (cmd_reg == CMD_GRAVITY);

   // Compare with >= so a period shortened below the running count wraps at once.
   always_comb begin
      period_eff = (i_gravity_period < TICK_W'(2)) ? TICK_W'(2) : i_gravity_period;
      tick       = !i_pause && (timer_reg >= period_eff - TICK_W'(1));
      timer_next = timer_reg;
      grav_next  = grav_reg;
      if (accept_hard)   timer_next = '0;
      else if (tick)     timer_next = '0;
      else if (!i_pause) timer_next = timer_reg + TICK_W'(1);
      if (accept_hard || accept_grav) grav_next = 1'b0;
      if (tick && !accept_hard)       grav_next = 1'b1;
   end

   always_comb begin
      state_next = state_reg;
      valid_next = valid_reg;
      cmd_next   = cmd_reg;
      pop        = 1'b0;
      case (state_reg)
         IDLE: begin
            if (i_frame_start && !i_pause) begin
               if (grav_reg) begin
                  state_next = GRAV;
                  valid_next = 1'b1;
                  cmd_next   = CMD_GRAVITY;
               end else if (!fifo_empty) begin
                  state_next = KEY;
                  valid_next = 1'b1;
                  cmd_next   = cmd_e'(fifo_head);
               end
            end
         end
         GRAV: begin
            if (accept) begin
               if (!fifo_empty) begin
                  state_next = KEY;
                  cmd_next   = cmd_e'(fifo_head);
               end else begin
                  state_next = IDLE;
                  valid_next = 1'b0;
                  cmd_next   = CMD_NOP;
               end
            end
         end
         KEY: begin
            if (accept) begin
               pop        = 1'b1;
               state_next = IDLE;
               valid_next = 1'b0;
               cmd_next   = CMD_NOP;
            end
         end
         default: begin
            state_next = IDLE;
            valid_next = 1'b0;
            cmd_next   = CMD_NOP;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg    <= IDLE;
         valid_reg    <= 1'b0;
         cmd_reg      <= CMD_NOP;
         ext_reg      <= 1'b0;
         brk_reg      <= 1'b0;
         overflow_reg <= 1'b0;
         grav_reg     <= 1'b0;
         timer_reg    <= '0;
      end else begin
         state_reg    <= state_next;
         valid_reg    <= valid_next;
         cmd_reg      <= cmd_next;
         ext_reg      <= ext_next;
         brk_reg      <= brk_next;
         overflow_reg <= overflow_next;
         grav_reg     <= grav_next;
         timer_reg    <= timer_next;
      end
   end

   assign o_cmd_valid = valid_reg;
   assign o_cmd       = cmd_reg;
   assign o_overflow  = overflow_reg;

endmodule

// File: tb/tb_game_cmd_scheduler.sv
// Scoreboard bench: expected commands queued at stimulus, compared against accepted commands.
module tb_game_cmd_scheduler;
   import game_pkg::*;

   localparam int DEPTH = 4;
   localparam int TW    = 27;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          key_valid = 1'b0;
   logic [7:0]    key_code = 8'h00;
   logic          frame = 1'b0;
   logic          pause = 1'b0;
   logic          ready = 1'b0;
   logic [TW-1:0] period = '1;
   logic          cmd_valid;
   logic [2:0]    cmd;
   logic [2:0]    count;
   logic          overflow;

   int         checks = 0;
   int         errors = 0;
   logic [2:0] exp_q[$];
   logic [2:0] obs_q[$];

   game_cmd_scheduler #(
      .FIFO_DEPTH (DEPTH),
      .TICK_W     (TW)
   ) dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .i_key_valid      (key_valid),
      .i_key_code       (key_code),
      .i_frame_start    (frame),
      .i_pause          (pause),
      .i_gravity_period (period),
      .o_cmd_valid      (cmd_valid),
      .o_cmd            (cmd),
      .i_cmd_ready      (ready),
      .o_fifo_count     (count),
      .o_overflow       (overflow)
   );

   always #5 clk = ~clk;

   // Record every command the DUT hands over (valid && ready at the coming edge).
   always @(negedge clk) begin
      if (rst_n && cmd_valid && ready) obs_q.push_back(cmd);
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n = 1'b0; key_valid = 1'b0; frame = 1'b0; pause = 1'b0; ready = 1'b0; period = '1;
      step(2);
      exp_q.delete();
      obs_q.delete();
      rst_n = 1'b1;
      step(1);
   endtask

   task automatic send_key(input logic [7:0] b);
      key_valid = 1'b1; key_code = b;
      step(1);
      key_valid = 1'b0;
   endtask

   task automatic pulse_frame;
      frame = 1'b1;
      step(1);
      frame = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; period = '1;
      step(2);
      checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", cmd_valid); end
      checks++; if (cmd !== 3'd0) begin errors++; $display("FAIL reset_cmd got %0d exp 0", cmd); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
      rst_n = 1'b1;
      step(3);
      checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b exp 0", cmd_valid); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL idle_count got %0d exp 0", count); end
      $display("test_reset done");
   endtask

   task automatic test_ext_left;
      int vcnt;
      logic [2:0] e, o;
      do_reset();
      send_key(SC_EXT);
      send_key(SC_LEFT);
      exp_q.push_back(3'd1);
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL ext_left_count got %0d exp 1", count); end
      ready = 1'b1;
      pulse_frame();
      checks++; if (cmd_valid !== 1'b1 || cmd !== 3'd1) begin errors++; $display("FAIL ext_left_issue got v=%b c=%0d exp v=1 c=1", cmd_valid, cmd); end
      vcnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (cmd_valid) vcnt++;
         step(1);
      end
      checks++; if (vcnt != 1) begin errors++; $display("FAIL ext_left_valid_cycles got %0d exp 1", vcnt); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL ext_left_count_after got %0d exp 0", count); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 3'd7;
         checks++; if (o !== e) begin errors++; $display("FAIL ext_left_sb got %0d exp %0d", o, e); end
      end
      checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL ext_left_extra got %0d extra exp 0", obs_q.size()); end
      ready = 1'b0;
      $display("test_ext_left done");
   endtask

   task automatic test_break;
      int vcnt;
      do_reset();
      send_key(SC_BRK);
      send_key(SC_LEFT);
      send_key(8'h1C);
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL break_count got %0d exp 0", count); end
      ready = 1'b1;
      pulse_frame();
      vcnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (cmd_valid) vcnt++;
         step(1);
      end
      checks++; if (vcnt != 0) begin errors++; $display("FAIL break_valid_cycles got %0d exp 0", vcnt); end
      checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL break_extra got %0d cmds exp 0", obs_q.size()); end
      ready = 1'b0;
      $display("test_break done");
   endtask

   task automatic test_gravity;
      int vcnt;
      logic [2:0] e, o;
      do_reset();
      period = TW'(10);
      ready = 1'b1;
      step(25);
      vcnt = 0;
      for (int f = 0; f < 4; f++) begin
         exp_q.push_back(3'd6);
         pulse_frame();
         for (int i = 0; i < 24; i++) begin
            if (cmd_valid) vcnt++;
            step(1);
         end
      end
      checks++; if (vcnt != 4) begin errors++; $display("FAIL gravity_valid_cycles got %0d exp 4", vcnt); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 3'd7;
         checks++; if (o !== e) begin errors++; $display("FAIL gravity_sb got %0d exp %0d", o, e); end
      end
      checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL gravity_extra got %0d extra exp 0", obs_q.size()); end
      ready = 1'b0; period = '1;
      $display("test_gravity done");
   endtask

   task automatic test_back_to_back;
      logic [2:0] e, o;
      do_reset();
      period = TW'(10);
      step(15);
      period = '1;
      send_key(SC_RIGHT);
      exp_q.push_back(3'd6);
      exp_q.push_back(3'd2);
      ready = 1'b1;
      pulse_frame();
      checks++; if (cmd_valid !== 1'b1 || cmd !== 3'd6) begin errors++; $display("FAIL b2b_first got v=%b c=%0d exp v=1 c=6", cmd_valid, cmd); end
      step(1);
      checks++; if (cmd_valid !== 1'b1 || cmd !== 3'd2) begin errors++; $display("FAIL b2b_second got v=%b c=%0d exp v=1 c=2", cmd_valid, cmd); end
      step(1);
      checks++; if (cmd_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL b2b_end got v=%b n=%0d exp v=0 n=0", cmd_valid, count); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 3'd7;
         checks++; if (o !== e) begin errors++; $display("FAIL b2b_sb got %0d exp %0d", o, e); end
      end
      checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL b2b_extra got %0d extra exp 0", obs_q.size()); end
      ready = 1'b0;
      $display("test_back_to_back done");
   endtask

   task automatic test_overflow;
      logic [7:0] codes [5] = '{8'h72, 8'h29, 8'h75, 8'h6B, 8'h74};
      logic [2:0] cmds  [5] = '{3'd4, 3'd5, 3'd3, 3'd1, 3'd2};
      int model;
      logic [2:0] e, o;
      do_reset();
      model = 0;
      for (int i = 0; i < 5; i++) begin
         send_key(codes[i]);
         if (model < DEPTH) begin exp_q.push_back(cmds[i]); model++; end
      end
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d exp 4", count); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
      pulse_frame();
      checks++; if (cmd_valid !== 1'b1 || cmd !== 3'd4) begin errors++; $display("FAIL ovf_head got v=%b c=%0d exp v=1 c=4", cmd_valid, cmd); end
      ready = 1'b1; key_valid = 1'b1; key_code = SC_UP;
      exp_q.push_back(3'd3);
      step(1);
      key_valid = 1'b0; ready = 1'b0;
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_push_pop_count got %0d exp 4", count); end
      ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         pulse_frame();
         step(2);
      end
      checks++; if (count !== 3'd0 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_drain got n=%0d ovf=%b exp n=0 ovf=1", count, overflow); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 3'd7;
         checks++; if (o !== e) begin errors++; $display("FAIL ovf_sb got %0d exp %0d", o, e); end
      end
      checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL ovf_extra got %0d extra exp 0", obs_q.size()); end
      ready = 1'b0;
      $display("test_overflow done");
   endtask

   task automatic test_pause_hold;
      do_reset();
      send_key(SC_LEFT);
      pause = 1'b1;
      pulse_frame();
      checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL pause_blocks got v=%b exp 0", cmd_valid); end
      pause = 1'b0;
      pulse_frame();
      checks++; if (cmd_valid !== 1'b1 || cmd !== 3'd1) begin errors++; $display("FAIL hold_issue got v=%b c=%0d exp v=1 c=1", cmd_valid, cmd); end
      pause = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(1);
         checks++; if (cmd_valid !== 1'b1 || cmd !== 3'd1) begin errors++; $display("FAIL hold_cycle%0d got v=%b c=%0d exp v=1 c=1", i, cmd_valid, cmd); end
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (cmd_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL async_reset got v=%b n=%0d exp v=0 n=0", cmd_valid, count); end
      step(1);
      rst_n = 1'b1; pause = 1'b0;
      step(1);
      checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL hold_extra got %0d cmds exp 0", obs_q.size()); end
      $display("test_pause_hold done");
   endtask

   initial begin
      test_reset();
      test_ext_left();
      test_break();
      test_gravity();
      test_back_to_back();
      test_overflow();
      test_pause_hold();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
